// File: rtl/alu_in_arbiter.sv
// Round-robin arbiter sharing one alu_in initiator port among NUM_REQ
// requesters. A one-entry registered output stage allows one issue per
// cycle, and a small FSM sequences ALU soft-reset pulses after the
// outstanding command has been handed off.
module alu_in_arbiter #(
    parameter  int NUM_REQ         = 4,
    parameter  int ALU_IN_OP_WIDTH = 8,
    parameter  int RST_CYCLES      = 2,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*3-1:0]                 req_op_i,
    input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]   req_b_i,
    input  logic                                 soft_rst_req_i,
    input  logic                                 alu_ready_i,
    output logic                                 alu_valid_o,
    output logic [2:0]                           alu_op_o,
    output logic [ALU_IN_OP_WIDTH-1:0]           alu_a_o,
    output logic [ALU_IN_OP_WIDTH-1:0]           alu_b_o,
    output logic                                 alu_rst_o,
    output logic [ID_W-1:0]                      grant_id_o,
    output logic                                 busy_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESET = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(RST_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       rst_pending_q, rst_pending_d;
    logic                       alu_rst_q, alu_rst_d;
    logic                       valid_q, valid_d;
    logic [2:0]                 op_q, op_d;
    logic [ALU_IN_OP_WIDTH-1:0] a_q, a_d;
    logic [ALU_IN_OP_WIDTH-1:0] b_q, b_d;
    logic [ID_W-1:0]            grant_q, grant_d;
    logic [ID_W-1:0]            last_q, last_d;

    logic accept;
    logic load;
    logic found;
    int   win;

    // The ALU takes the staged command when valid meets ready at the edge.
    assign accept = valid_q && alu_ready_i;

    // A soft-reset request arriving this cycle already blocks issue, so the
    // reset wins over a simultaneous command.
    assign load = rst_i && (state_q == ST_RUN) && !rst_pending_q && !soft_rst_req_i
                  && (!valid_q || alu_ready_i) && (|req_valid_i);

    // All state flops, cleared asynchronously; last resets so requester 0 wins first.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            rst_pending_q <= 1'b0;
            alu_rst_q     <= 1'b0;
            valid_q       <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            grant_q       <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_pending_q <= rst_pending_d;
            alu_rst_q     <= alu_rst_d;
            valid_q       <= valid_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
        end
    end

    // Soft-reset sequencing: latch the request, drain the stage, pulse alu_rst.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        rst_pending_d = rst_pending_q;
        alu_rst_d     = alu_rst_q;
        unique case (state_q)
            ST_RUN: begin
                if (rst_pending_q) begin
                    if (valid_q && !alu_ready_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d   = ST_RESET;
                        cnt_d     = CNT_INIT;
                        alu_rst_d = 1'b1;
                    end
                end else if (soft_rst_req_i) begin
                    rst_pending_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_d   = ST_RESET;
                    cnt_d     = CNT_INIT;
                    alu_rst_d = 1'b1;
                end
            end
            ST_RESET: begin
                if (cnt_q == 4'd0) begin
                    state_d       = ST_RUN;
                    alu_rst_d     = 1'b0;
                    rst_pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Round-robin pick starting after the last winner, then load or clear the stage.
    always_comb begin
        found       = 1'b0;
        win         = 0;
        req_ready_o = '0;
        valid_d     = valid_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        grant_d     = grant_q;
        last_d      = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = (int'(last_q) + k) % NUM_REQ;
            end
        end
        if (load) begin
            req_ready_o[win] = 1'b1;
            valid_d          = 1'b1;
            op_d             = req_op_i[3*win +: 3];
            a_d              = req_a_i[ALU_IN_OP_WIDTH*win +: ALU_IN_OP_WIDTH];
            b_d              = req_b_i[ALU_IN_OP_WIDTH*win +: ALU_IN_OP_WIDTH];
            grant_d          = ID_W'(win);
            last_d           = ID_W'(win);
        end else if (accept) begin
            valid_d = 1'b0;
            op_d    = '0;
            a_d     = '0;
            b_d     = '0;
            grant_d = '0;
        end
    end

    assign alu_valid_o = valid_q;
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_rst_o   = alu_rst_q;
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != ST_RUN) || valid_q;

endmodule

// File: tb/tb_alu_in_arbiter.sv
// Directed bench for alu_in_arbiter: a per-cycle vector table for the
// main scenarios plus a hand-written async-reset sequence.
module tb_alu_in_arbiter;

    localparam logic [11:0] OPS = {3'd7, 3'd1, 3'd6, 3'd5};
    localparam logic [31:0] AS  = {8'hA3, 8'h12, 8'hA1, 8'hA0};
    localparam logic [31:0] BS  = {8'hB3, 8'h34, 8'hB1, 8'hB0};

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [3:0] req_valid_i = '0;
    logic [3:0] req_ready_o;
    logic       soft_rst_req_i = 1'b0;
    logic       alu_ready_i = 1'b0;
    logic       alu_valid_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic       alu_rst_o;
    logic [1:0] grant_id_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    alu_in_arbiter #(.NUM_REQ(4), .ALU_IN_OP_WIDTH(8), .RST_CYCLES(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (OPS),
        .req_a_i        (AS),
        .req_b_i        (BS),
        .soft_rst_req_i (soft_rst_req_i),
        .alu_ready_i    (alu_ready_i),
        .alu_valid_o    (alu_valid_o),
        .alu_op_o       (alu_op_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_rst_o      (alu_rst_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] vld;
        logic       srst;
        logic       rdy;
        logic [3:0] e_rr;
        logic       e_v;
        logic [1:0] e_g;
        logic       e_rst;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] vld, input logic srst, input logic rdy,
                                input logic [3:0] rr, input logic v, input logic [1:0] g,
                                input logic rst, input logic busy);
        vec_t t;
        t.vld = vld; t.srst = srst; t.rdy = rdy;
        t.e_rr = rr; t.e_v = v; t.e_g = g; t.e_rst = rst; t.e_busy = busy;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Registered stage contents expected for a given valid/grant pair.
    task automatic check_stage(input string tag, input logic v, input logic [1:0] g);
        logic [2:0] eop;
        logic [7:0] ea;
        logic [7:0] eb;
        eop = v ? OPS[3*g +: 3] : 3'd0;
        ea  = v ? AS[8*g +: 8]  : 8'd0;
        eb  = v ? BS[8*g +: 8]  : 8'd0;
        check({tag, "_valid"}, 32'(alu_valid_o), 32'(v));
        check({tag, "_op"},    32'(alu_op_o),    32'(eop));
        check({tag, "_a"},     32'(alu_a_o),     32'(ea));
        check({tag, "_b"},     32'(alu_b_o),     32'(eb));
        if (v) check({tag, "_grant"}, 32'(grant_id_o), 32'(g));
    endtask

    initial begin
        // Single request to requester 2 (last starts at 3).
        vecs.push_back(mk(4'b0100, 0, 1, 4'b0100, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 1, 2, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0));
        // Round robin with all valid: last=2, so 3,0,1,2,3,0.
        vecs.push_back(mk(4'b1111, 0, 1, 4'b1000, 0, 0, 0, 0));
        vecs.push_back(mk(4'b1111, 0, 1, 4'b0001, 1, 3, 0, 1));
        vecs.push_back(mk(4'b1111, 0, 1, 4'b0010, 1, 0, 0, 1));
        vecs.push_back(mk(4'b1111, 0, 1, 4'b0100, 1, 1, 0, 1));
        vecs.push_back(mk(4'b1111, 0, 1, 4'b1000, 1, 2, 0, 1));
        vecs.push_back(mk(4'b1111, 0, 1, 4'b0001, 1, 3, 0, 1));
        // Backpressure for 5 cycles, stage holds requester 0.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(4'b1111, 0, 0, 4'b0000, 1, 0, 0, 1));
        // Accept and reload requester 1 in the same cycle.
        vecs.push_back(mk(4'b0010, 0, 1, 4'b0010, 1, 0, 0, 1));
        // Soft reset while stalled: pending, DRAIN, accept, 2 reset cycles.
        vecs.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0001, 0, 0, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0001, 0, 0, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 1, 1, 0, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0001, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0));
        // Reset priority over a same-cycle request; a pulse during RESET is absorbed.
        vecs.push_back(mk(4'b0001, 1, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0001, 1, 1, 4'b0000, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0000, 0, 0, 1, 1));
        vecs.push_back(mk(4'b0001, 0, 1, 4'b0001, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 1, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 0, 0));

        // Power-on reset state.
        #12;
        check_stage("por", 1'b0, 2'd0);
        check("por_rst",  32'(alu_rst_o),  32'd0);
        check("por_busy", 32'(busy_o),     32'd0);
        check("por_gid",  32'(grant_id_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag            = $sformatf("v%0d", i);
            req_valid_i    = vecs[i].vld;
            soft_rst_req_i = vecs[i].srst;
            alu_ready_i    = vecs[i].rdy;
            #3;
            check({tag, "_req_ready"}, 32'(req_ready_o), 32'(vecs[i].e_rr));
            check({tag, "_alu_rst"},   32'(alu_rst_o),   32'(vecs[i].e_rst));
            check({tag, "_busy"},      32'(busy_o),      32'(vecs[i].e_busy));
            check_stage(tag, vecs[i].e_v, vecs[i].e_g);
            @(posedge clk_i); #1;
        end

        // Async reset in the first RESET cycle (cnt = 1), with requester 0 staged earlier.
        req_valid_i    = 4'b0000;
        soft_rst_req_i = 1'b1;
        alu_ready_i    = 1'b1;
        @(posedge clk_i); #1;
        soft_rst_req_i = 1'b0;
        @(posedge clk_i); #1;
        check("ar_pre_rst", 32'(alu_rst_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("ar_rst",       32'(alu_rst_o),   32'd0);
        check("ar_busy",      32'(busy_o),      32'd0);
        check("ar_req_ready", 32'(req_ready_o), 32'd0);
        check("ar_gid",       32'(grant_id_o),  32'd0);
        check_stage("ar", 1'b0, 2'd0);
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        req_valid_i = 4'b1111;
        #3;
        check("post_req_ready", 32'(req_ready_o), 32'b0001);
        check("post_rst",       32'(alu_rst_o),   32'd0);
        @(posedge clk_i); #1;
        req_valid_i = 4'b0000;
        #3;
        check_stage("post", 1'b1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
